exception_sequencer: RTL

//  Control FSM sequencing entry to and return from interrupt/syscall handlers around CP0.
//  On a CP0 request (S_INT) it stalls the front-end and drains the MEM stage.
//  It then flushes IF/ID/EX, strobes CP0 to latch EPC, and redirects the PC to the handler entry.
//  On ERET it flushes and redirects to the EPC. It tracks handler nesting depth.

---
 rtl/exception_sequencer_pkg.sv | 22 ++
 rtl/exception_sequencer_drain_timer.sv | 25 ++
 rtl/exception_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/exception_sequencer_pkg.sv
// Shared types and constants for the CP0 exception entry/return sequencer.
package exception_sequencer_pkg;

   localparam int unsigned ADDR_W = 32;

   // CP0 register indices touched by the sequence
   localparam logic [4:0] CP0_IDX_CAUSE = 5'd13;
   localparam logic [4:0] CP0_IDX_EPC   = 5'd14;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAIN = 3'd1,
      ST_FLUSH = 3'd2,
      ST_REDIR = 3'd3,
      ST_RET   = 3'd4
   } seq_state_e;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/exception_sequencer_drain_timer.sv
// Drain-wait counter: synchronous clear, count enable, terminal-count flag.
module exception_sequencer_drain_timer #(
   parameter int unsigned DCNT_W = 5,
   parameter int unsigned TC_CNT = 15
) (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc_c
);

   localparam logic [DCNT_W-1:0] LP_TC = DCNT_W'(TC_CNT);

   logic [DCNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn)    r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_en)    r_cnt <= r_cnt + DCNT_W'(1);
   end

   assign o_tc_c = (r_cnt == LP_TC);

endmodule

// File: rtl/exception_sequencer.sv
// Sequences handler entry (stall, drain MEM, flush, CP0 take, redirect) and ERET return.
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter int unsigned MAX_NEST  = 4,
   parameter int unsigned DRAIN_MAX = 16,
   parameter int unsigned NEST_W    = 3,
   parameter int unsigned DCNT_W    = 5
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_s_int,
   input  logic              i_s_eret,
   input  logic              i_pipeline_ready,
   input  logic              i_mem_busy,
   input  logic [31:0]       i_resume_pc,
   input  logic [31:0]       i_int_enter,
   input  logic [31:0]       i_epc,
   output logic              o_stall,
   output logic              o_flush,
   output logic [31:0]       o_epc_in,
   output logic              o_cp0_take,
   output logic              o_pc_redirect,
   output logic [31:0]       o_pc_target,
   output logic [NEST_W-1:0] o_nest_depth,
   output logic              o_drain_err
);

   localparam logic [NEST_W-1:0] LP_MAX_NEST = NEST_W'(MAX_NEST);

   seq_state_e        r_state, w_state_nxt;
   logic              w_tc, w_drain_ok;
   logic              w_stall, w_flush, w_cp0_take, w_redirect;
   logic              r_stall, r_flush, r_cp0_take, r_redirect, r_drain_err;
   logic [31:0]       r_epc_q, r_epc_in, r_tgt;
   logic [NEST_W-1:0] r_depth;

   assign w_drain_ok = !i_mem_busy && i_pipeline_ready;

   exception_sequencer_drain_timer #(
      .DCNT_W (DCNT_W),
      .TC_CNT (DRAIN_MAX - 1)
   ) u_drain_timer (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_clear  (r_state != ST_DRAIN),
      .i_en     (r_state == ST_DRAIN),
      .o_tc_c   (w_tc)
   );

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Interrupt wins over a same-cycle ERET; the squashed ERET re-executes later
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_s_int && (r_depth < LP_MAX_NEST))
               w_state_nxt = ST_DRAIN;
            else if (i_s_eret && i_pipeline_ready && (r_depth != '0))
               w_state_nxt = ST_RET;
         end
         ST_DRAIN: if (w_drain_ok || w_tc) w_state_nxt = ST_FLUSH;
         ST_FLUSH: w_state_nxt = ST_REDIR;
         ST_REDIR: w_state_nxt = ST_IDLE;
         ST_RET:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the next state so the registered copies line up with it
   always_comb begin
      w_stall    = 1'b0;
      w_flush    = 1'b0;
      w_cp0_take = 1'b0;
      w_redirect = 1'b0;
      case (w_state_nxt)
         ST_DRAIN: w_stall = 1'b1;
         ST_FLUSH: begin
            w_stall    = 1'b1;
            w_flush    = 1'b1;
            w_cp0_take = 1'b1;
         end
         ST_REDIR: w_redirect = 1'b1;
         ST_RET: begin
            w_flush    = 1'b1;
            w_redirect = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_stall     <= 1'b0;
         r_flush     <= 1'b0;
         r_cp0_take  <= 1'b0;
         r_redirect  <= 1'b0;
         r_drain_err <= 1'b0;
         r_epc_q     <= '0;
         r_epc_in    <= '0;
         r_tgt       <= '0;
         r_depth     <= '0;
      end else begin
         r_stall    <= w_stall;
         r_flush    <= w_flush;
         r_cp0_take <= w_cp0_take;
         r_redirect <= w_redirect;
         if (r_state == ST_IDLE && w_state_nxt == ST_DRAIN)
            r_epc_q <= word_align(i_resume_pc);
         if (r_state == ST_DRAIN && w_state_nxt == ST_FLUSH)
            r_epc_in <= r_epc_q;
         if (r_state == ST_IDLE && w_state_nxt == ST_RET)
            r_tgt <= word_align(i_epc);
         else if (r_state == ST_FLUSH)
            r_tgt <= word_align(i_int_enter);
         if (r_state == ST_REDIR && r_depth < LP_MAX_NEST)
            r_depth <= r_depth + NEST_W'(1);
         else if (r_state == ST_RET && r_depth != '0)
            r_depth <= r_depth - NEST_W'(1);
         if (r_state == ST_DRAIN && w_tc && !w_drain_ok)
            r_drain_err <= 1'b1;
      end
   end

   assign o_stall       = r_stall;
   assign o_flush       = r_flush;
   assign o_cp0_take    = r_cp0_take;
   assign o_pc_redirect = r_redirect;
   assign o_epc_in      = r_epc_in;
   assign o_pc_target   = r_tgt;
   assign o_nest_depth  = r_depth;
   assign o_drain_err   = r_drain_err;

endmodule
